// File: rtl/alu_console.sv
// Switch/button ALU console: debounced operation select, RUN/HOLD result freeze, registered result and flags.
// Define ALU_CONSOLE_MUL_EN to build the op-7 multiplier; without it op 7 returns zero.
module alu_console #(
  parameter int WIDTH     = 4,
  parameter int DB_CYCLES = 500000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     sw_data_1,
  input  logic [WIDTH-1:0]     sw_data_2,
  input  logic                 btn_next,
  input  logic                 btn_prev,
  input  logic                 btn_hold,
  output logic [2:0]           sel,
  output logic [2*WIDTH-1:0]   alu_out,
  output logic                 flag_zero,
  output logic                 flag_carry,
  output logic                 hold,
  output logic                 res_valid
);

  typedef enum logic {MODE_RUN, MODE_HOLD} mode_e;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_MUL
  } op_e;

  localparam int                CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [WIDTH-1:0]  WIDTH_V  = WIDTH[WIDTH-1:0];

  // ---------------- two-flop synchronisers ----------------
  logic [WIDTH-1:0] a_s1_q, a_s2_q, b_s1_q, b_s2_q;
  logic [2:0]       btn_s1_q, btn_s2_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_s1_q   <= '0;
      a_s2_q   <= '0;
      b_s1_q   <= '0;
      b_s2_q   <= '0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
    end else begin
      a_s1_q   <= sw_data_1;
      a_s2_q   <= a_s1_q;
      b_s1_q   <= sw_data_2;
      b_s2_q   <= b_s1_q;
      btn_s1_q <= {btn_hold, btn_prev, btn_next};
      btn_s2_q <= btn_s1_q;
    end
  end

  // ---------------- per-button debounce ----------------
  // A button is only armed after a full stable-low window, so one held through reset never ticks.
  logic [2:0] tick;

  for (genvar i = 0; i < 3; i++) begin : g_db
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             armed_q, armed_d;
    logic             tick_w;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      armed_d = armed_q;
      tick_w  = 1'b0;
      if (!armed_q) begin
        if (!btn_s2_q[i]) begin
          if (cnt_q == CNT_LAST) armed_d = 1'b1;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end else if (btn_s2_q[i] != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_d = btn_s2_q[i];
          tick_w  = btn_s2_q[i];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q   <= '0;
        level_q <= 1'b0;
        armed_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        level_q <= level_d;
        armed_q <= armed_d;
      end
    end

    assign tick[i] = tick_w;
  end

  wire tick_next = tick[0];
  wire tick_prev = tick[1];
  wire tick_hold = tick[2];

  // ---------------- operation select and mode FSM ----------------
  logic [2:0] sel_q, sel_d;
  mode_e      mode_q, mode_d;

  always_comb begin
    sel_d  = sel_q;
    mode_d = mode_q;
    case ({tick_next, tick_prev})
      2'b10:   sel_d = sel_q + 3'd1;
      2'b01:   sel_d = sel_q - 3'd1;
      default: sel_d = sel_q;
    endcase
    if (tick_hold) mode_d = (mode_q == MODE_RUN) ? MODE_HOLD : MODE_RUN;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q  <= 3'd0;
      mode_q <= MODE_RUN;
    end else begin
      sel_q  <= sel_d;
      mode_q <= mode_d;
    end
  end

  // ---------------- ALU datapath ----------------
  logic [WIDTH:0]       sum_w, diff_w;
  logic [WIDTH-1:0]     shamt_w;
  logic [2*WIDTH-1:0]   shl_w, res_w;
  logic                 carry_w;

  always_comb begin
    sum_w   = {1'b0, a_s2_q} + {1'b0, b_s2_q};
    diff_w  = {1'b0, a_s2_q} - {1'b0, b_s2_q};
    shamt_w = b_s2_q % WIDTH_V;
    shl_w   = {{WIDTH{1'b0}}, a_s2_q} << shamt_w;
    res_w   = '0;
    carry_w = 1'b0;
    case (op_e'(sel_q))
      OP_ADD: begin
        res_w[WIDTH-1:0] = sum_w[WIDTH-1:0];
        carry_w          = sum_w[WIDTH];
      end
      OP_SUB: begin
        res_w[WIDTH-1:0] = diff_w[WIDTH-1:0];
        carry_w          = diff_w[WIDTH];
      end
      OP_AND: res_w[WIDTH-1:0] = a_s2_q & b_s2_q;
      OP_OR:  res_w[WIDTH-1:0] = a_s2_q | b_s2_q;
      OP_XOR: res_w[WIDTH-1:0] = a_s2_q ^ b_s2_q;
      OP_NOT: res_w[WIDTH-1:0] = ~a_s2_q;
      OP_SHL: begin
        res_w[WIDTH-1:0] = shl_w[WIDTH-1:0];
        carry_w          = |shl_w[2*WIDTH-1:WIDTH];
      end
      OP_MUL: begin
`ifdef ALU_CONSOLE_MUL_EN
        res_w = {{WIDTH{1'b0}}, a_s2_q} * {{WIDTH{1'b0}}, b_s2_q};
`else
        res_w = '0;
`endif
      end
      default: res_w = '0;
    endcase
  end

  // ---------------- result register ----------------
  // Result and both flags share one register stage so they always describe the same value.
  logic [2*WIDTH-1:0] alu_q, alu_d;
  logic               zero_q, zero_d, carry_q, carry_d, valid_q, valid_d;

  always_comb begin
    alu_d   = alu_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    valid_d = 1'b0;
    if (mode_q == MODE_RUN) begin
      alu_d   = res_w;
      zero_d  = (res_w == '0);
      carry_d = carry_w;
      valid_d = (res_w != alu_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_q   <= '0;
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      alu_q   <= alu_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  assign sel        = sel_q;
  assign alu_out    = alu_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign hold       = (mode_q == MODE_HOLD);
  assign res_valid  = valid_q;

endmodule

// File: tb/tb_alu_console.sv
// Directed self-checking bench for alu_console (WIDTH=4, DB_CYCLES=4).
module tb_alu_console;

  localparam int WIDTH = 4;
  localparam int DB    = 4;
  localparam logic [2:0] B_NEXT = 3'b001;
  localparam logic [2:0] B_PREV = 3'b010;
  localparam logic [2:0] B_HOLD = 3'b100;

`ifdef ALU_CONSOLE_MUL_EN
  localparam logic [7:0] MUL_EXP  = 8'hE1;
  localparam logic       MUL_ZERO = 1'b0;
`else
  localparam logic [7:0] MUL_EXP  = 8'h00;
  localparam logic       MUL_ZERO = 1'b1;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] sw_data_1, sw_data_2;
  logic             btn_next, btn_prev, btn_hold;
  logic [2:0]       sel;
  logic [2*WIDTH-1:0] alu_out;
  logic             flag_zero, flag_carry, hold, res_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses;

  alu_console #(.WIDTH(WIDTH), .DB_CYCLES(DB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw_data_1  (sw_data_1),
    .sw_data_2  (sw_data_2),
    .btn_next   (btn_next),
    .btn_prev   (btn_prev),
    .btn_hold   (btn_hold),
    .sel        (sel),
    .alu_out    (alu_out),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .hold       (hold),
    .res_valid  (res_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait n cycles, counting res_valid pulses seen at each falling edge.
  task automatic wait_count(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (res_valid) cnt++;
    end
  endtask

  // Hold the selected buttons long enough to be accepted, then release them fully.
  task automatic press(input logic [2:0] m, output int cnt);
    int c1, c2;
    {btn_hold, btn_prev, btn_next} = m;
    wait_count(DB + 8, c1);
    {btn_hold, btn_prev, btn_next} = 3'b000;
    wait_count(DB + 8, c2);
    cnt = c1 + c2;
  endtask

  task automatic set_ops(input logic [3:0] a, input logic [3:0] b);
    sw_data_1 = a;
    sw_data_2 = b;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    reset_n   = 1'b0;
    sw_data_1 = '0;
    sw_data_2 = '0;
    btn_next  = 1'b0;
    btn_prev  = 1'b0;
    btn_hold  = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_sel",   sel,        0);
    check("rst_alu",   alu_out,    0);
    check("rst_zero",  flag_zero,  1);
    check("rst_carry", flag_carry, 0);
    check("rst_valid", res_valid,  0);
    check("rst_hold",  hold,       0);

    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // ADD with carry out of the operand width
    sw_data_1 = 4'h9;
    sw_data_2 = 4'h8;
    wait_count(8, pulses);
    check("add_alu",    alu_out,    8'h01);
    check("add_carry",  flag_carry, 1);
    check("add_zero",   flag_zero,  0);
    check("add_pulses", pulses,     1);

    // sel walks forward through all eight codes and wraps
    for (int i = 1; i <= 8; i++) begin
      press(B_NEXT, pulses);
      check($sformatf("next_%0d", i), sel, i % 8);
    end
    press(B_PREV, pulses);
    check("prev_wrap", sel, 7);

    // short glitch is rejected
    btn_next = 1'b1;
    repeat (3) @(negedge clk);
    btn_next = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch", sel, 7);

    press(B_NEXT | B_PREV, pulses);
    check("both", sel, 7);

    press(B_NEXT, pulses);
    press(B_NEXT, pulses);
    check("sel_sub", sel, 1);
    set_ops(4'h3, 4'h5);
    check("sub_alu",   alu_out,    8'h0E);
    check("sub_carry", flag_carry, 1);

    press(B_NEXT, pulses);
    set_ops(4'hC, 4'hA);
    check("and_alu",   alu_out,    8'h08);
    check("and_carry", flag_carry, 0);
    press(B_NEXT, pulses);
    check("or_alu",    alu_out,    8'h0E);
    press(B_NEXT, pulses);
    check("xor_alu",   alu_out,    8'h06);
    check("xor_carry", flag_carry, 0);
    press(B_NEXT, pulses);
    check("not_alu",   alu_out,    8'h03);

    press(B_NEXT, pulses);
    check("sel_shl", sel, 6);
    set_ops(4'hC, 4'h1);
    check("shl1_alu",   alu_out,    8'h08);
    check("shl1_carry", flag_carry, 1);
    set_ops(4'hC, 4'h2);
    check("shl2_alu",   alu_out,    8'h00);
    check("shl2_carry", flag_carry, 1);
    check("shl2_zero",  flag_zero,  1);

    press(B_NEXT, pulses);
    set_ops(4'hF, 4'hF);
    check("mul_alu",   alu_out,    MUL_EXP);
    check("mul_zero",  flag_zero,  MUL_ZERO);
    check("mul_carry", flag_carry, 0);

    // freeze the result, then disturb operands and sel
    press(B_HOLD, pulses);
    check("hold_on", hold, 1);
    sw_data_1 = 4'h2;
    sw_data_2 = 4'h3;
    wait_count(8, pulses);
    check("hold_pulses", pulses,    0);
    check("hold_alu",    alu_out,   MUL_EXP);
    check("hold_zero",   flag_zero, MUL_ZERO);
    press(B_NEXT, pulses);
    check("hold_sel",     sel,     0);
    check("hold_alu2",    alu_out, MUL_EXP);
    check("hold_pulses2", pulses,  0);

    press(B_HOLD, pulses);
    check("run_hold",   hold,       0);
    check("run_alu",    alu_out,    8'h05);
    check("run_carry",  flag_carry, 0);
    check("run_pulses", pulses,     1);

    // reset in the middle of a debounce, with HOLD active and sel non-zero
    press(B_NEXT, pulses);
    check("pre_sel", sel, 1);
    press(B_HOLD, pulses);
    check("pre_hold", hold, 1);
    btn_next = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_sel",   sel,        0);
    check("mid_alu",   alu_out,    0);
    check("mid_zero",  flag_zero,  1);
    check("mid_carry", flag_carry, 0);
    check("mid_valid", res_valid,  0);
    check("mid_hold",  hold,       0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    check("held_no_tick", sel, 0);
    btn_next = 1'b0;
    repeat (12) @(negedge clk);
    press(B_NEXT, pulses);
    check("repress", sel, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
